dual_issue_scoreboard: RTL and testbench

- Decode-stage hazard tracker for the dual-issue core; sits directly upstream of the dual-write-port register file.
- Tracks in-flight writes per architectural register.
- Decides each cycle whether issue slot 1 and issue slot 2 may read their operands (rs1/rs2 and rs4/rs5) and issue.
- Observes the same two writeback ports (WE3/AD3, WE6/AD6) that drive the register file.

---
 rtl/dual_issue_scoreboard_pkg.sv | 15 +
 rtl/dual_issue_scoreboard_counter.sv | 41 ++++
 rtl/dual_issue_scoreboard.sv | 111 +++++++++++
 tb/tb_dual_issue_scoreboard.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared constants for the dual-issue decode scoreboard: default widths,
// register-file size and the hard-wired zero register.
package dual_issue_scoreboard_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 5;
  localparam int unsigned DEF_CNT_WIDTH     = 2;
  localparam int unsigned REG_ZERO          = 0;

  function automatic int unsigned num_regs(input int unsigned aw);
    return 1 << aw;
  endfunction

  localparam int unsigned NUM_REGS = num_regs(DEF_ADDRESS_WIDTH);

endpackage

// File: rtl/dual_issue_scoreboard_counter.sv
// Pending-write counter for one architectural register: net up/down update,
// clamp at zero with an underflow flag, synchronous flush.
module scoreboard_counter
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 inc_i,
  input  logic [1:0]           dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 underflow_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   sum, dec_ext;

  always_comb begin
    sum         = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc_i);
    dec_ext     = (CNT_WIDTH+1)'(dec_i);
    // Underflow is judged against the old count; flush suppresses it.
    underflow_o = !flush_i && (dec_ext > {1'b0, cnt_q});
    cnt_d       = '0;
    if (!flush_i && (sum >= dec_ext)) begin
      cnt_d = CNT_WIDTH'(sum - dec_ext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Decode-stage hazard tracker for the dual-issue core: per-register pending
// write counts, slot issue decisions and sticky writeback-underflow error.
module dual_issue_scoreboard
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            v1,
  input  logic                            rd1_we,
  input  logic [ADDRESS_WIDTH-1:0]        rd1,
  input  logic [ADDRESS_WIDTH-1:0]        rs1,
  input  logic [ADDRESS_WIDTH-1:0]        rs2,
  input  logic                            v2,
  input  logic                            rd2_we,
  input  logic [ADDRESS_WIDTH-1:0]        rd2,
  input  logic [ADDRESS_WIDTH-1:0]        rs4,
  input  logic [ADDRESS_WIDTH-1:0]        rs5,
  input  logic                            WE3,
  input  logic [ADDRESS_WIDTH-1:0]        AD3,
  input  logic                            WE6,
  input  logic [ADDRESS_WIDTH-1:0]        AD6,
  output logic                            issue1,
  output logic                            issue2,
  output logic [(1<<ADDRESS_WIDTH)-1:0]   busy,
  output logic                            err
);

  localparam int unsigned                  NREGS   = num_regs(ADDRESS_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0]     RZ      = ADDRESS_WIDTH'(REG_ZERO);
  localparam logic [CNT_WIDTH-1:0]         CNT_MAX = '1;

  logic [NREGS-1:0][CNT_WIDTH-1:0] cnt;
  logic [NREGS-1:0]                wb3_hit, wb6_hit, rdy, uf;
  logic [NREGS-1:1]                inc;
  logic                            sat1, sat2, raw_pair, waw_pair;
  logic                            err_q, err_d;

  // Same-cycle writeback is visible to decode (register file writes on negedge).
  always_comb begin
    wb3_hit = '0;
    wb6_hit = '0;
    rdy     = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      wb3_hit[r] = WE3 && (AD3 == ADDRESS_WIDTH'(r));
      wb6_hit[r] = WE6 && (AD6 == ADDRESS_WIDTH'(r));
      rdy[r]     = (cnt[r] == '0) ||
                   ((cnt[r] == CNT_WIDTH'(1)) && (wb3_hit[r] || wb6_hit[r]));
    end
  end

  always_comb begin
    sat1     = rd1_we && (rd1 != RZ) && (cnt[rd1] == CNT_MAX);
    sat2     = rd2_we && (rd2 != RZ) && (cnt[rd2] == CNT_MAX);
    raw_pair = rd1_we && (rd1 != RZ) && ((rs4 == rd1) || (rs5 == rd1));
    waw_pair = rd1_we && rd2_we && (rd1 == rd2) && (rd1 != RZ);
    issue1   = v1 && rdy[rs1] && rdy[rs2] && !sat1;
    issue2   = issue1 && v2 && rdy[rs4] && rdy[rs5] && !sat2 && !raw_pair && !waw_pair;
  end

  // WAW split guarantees at most one increment per register per cycle.
  always_comb begin
    inc = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      inc[r] = (issue1 && rd1_we && (rd1 == ADDRESS_WIDTH'(r))) ||
               (issue2 && rd2_we && (rd2 == ADDRESS_WIDTH'(r)));
    end
  end

  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    scoreboard_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .inc_i      (inc[g]),
      .dec_i      (2'(wb3_hit[g]) + 2'(wb6_hit[g])),
      .cnt_o      (cnt[g]),
      .underflow_o(uf[g])
    );
  end

  always_comb begin
    err_d = err_q | (|uf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench for dual_issue_scoreboard: directed hazard scenarios
// followed by a randomized phase against a reference count model.
module tb_dual_issue_scoreboard;
  import dual_issue_scoreboard_pkg::*;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          v1, rd1_we, v2, rd2_we, WE3, WE6;
  logic [AW-1:0] rd1, rs1, rs2, rd2, rs4, rs5, AD3, AD6;
  logic          issue1, issue2, err;
  logic [31:0]   busy;

  dual_issue_scoreboard #(
    .ADDRESS_WIDTH(AW),
    .CNT_WIDTH    (2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .v1(v1), .rd1_we(rd1_we), .rd1(rd1), .rs1(rs1), .rs2(rs2),
    .v2(v2), .rd2_we(rd2_we), .rd2(rd2), .rs4(rs4), .rs5(rs5),
    .WE3(WE3), .AD3(AD3), .WE6(WE6), .AD6(AD6),
    .issue1(issue1), .issue2(issue2), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  int unsigned mc[NUM_REGS];
  bit          merr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_underrun", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  function automatic bit m_wb(input int unsigned r);
    return (WE3 && (AD3 == 5'(r))) || (WE6 && (AD6 == 5'(r)));
  endfunction

  function automatic bit m_rdy(input logic [AW-1:0] r);
    return (r == 0) || (mc[r] == 0) || ((mc[r] == 1) && m_wb(int'(r)));
  endfunction

  function automatic bit m_issue1();
    return v1 && m_rdy(rs1) && m_rdy(rs2) && !(rd1_we && rd1 != 0 && mc[rd1] == 3);
  endfunction

  function automatic bit m_issue2(input bit i1);
    bit raw, waw;
    raw = rd1_we && rd1 != 0 && (rs4 == rd1 || rs5 == rd1);
    waw = rd1_we && rd2_we && rd1 == rd2 && rd1 != 0;
    return i1 && v2 && m_rdy(rs4) && m_rdy(rs5) &&
           !(rd2_we && rd2 != 0 && mc[rd2] == 3) && !raw && !waw;
  endfunction

  task automatic m_update(input bit p1, input bit p2);
    int unsigned inc, dec;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        mc[r] = 0;
      end else begin
        inc = ((p1 && rd1_we && rd1 == 5'(r)) ? 1 : 0) + ((p2 && rd2_we && rd2 == 5'(r)) ? 1 : 0);
        dec = ((WE3 && AD3 == 5'(r)) ? 1 : 0) + ((WE6 && AD6 == 5'(r)) ? 1 : 0);
        if (dec > mc[r]) begin
          mc[r] = 0;
          merr  = 1'b1;
        end else begin
          mc[r] = mc[r] + inc - dec;
        end
      end
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) b[r] = (mc[r] != 0);
    return b;
  endfunction

  task automatic clear_inputs();
    flush = 0; v1 = 0; rd1_we = 0; rd1 = 0; rs1 = 0; rs2 = 0;
    v2 = 0; rd2_we = 0; rd2 = 0; rs4 = 0; rs5 = 0;
    WE3 = 0; AD3 = 0; WE6 = 0; AD6 = 0;
  endtask

  task automatic slot1(input bit v, input bit we, input int d, input int a, input int b);
    v1 = v; rd1_we = we; rd1 = 5'(d); rs1 = 5'(a); rs2 = 5'(b);
  endtask

  task automatic slot2(input bit v, input bit we, input int d, input int a, input int b);
    v2 = v; rd2_we = we; rd2 = 5'(d); rs4 = 5'(a); rs5 = 5'(b);
  endtask

  task automatic wb(input bit w3, input int a3, input bit w6, input int a6);
    WE3 = w3; AD3 = 5'(a3); WE6 = w6; AD6 = 5'(a6);
  endtask

  // Called at a negedge with inputs already applied.
  task automatic run_cycle(input bit use_model, input bit e1, input bit e2);
    bit p1, p2;
    if (use_model) begin
      p1 = m_issue1();
      p2 = m_issue2(p1);
    end else begin
      p1 = e1;
      p2 = e2;
    end
    push_exp("issue1", 32'(p1));
    push_exp("issue2", 32'(p2));
    #1;
    pop_chk(32'(issue1));
    pop_chk(32'(issue2));
    m_update(p1, p2);
    @(posedge clk);
    #1;
    push_exp("busy", m_busy());
    push_exp("err", 32'(merr));
    pop_chk(busy);
    pop_chk(32'(err));
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int unsigned r = 0; r < NUM_REGS; r++) mc[r] = 0;
    merr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    push_exp("reset_busy", 32'd0);
    push_exp("reset_err", 32'd0);
    push_exp("reset_issue1", 32'd0);
    pop_chk(busy);
    pop_chk(32'(err));
    pop_chk(32'(issue1));
    @(negedge clk);
    rst = 1'b0;

    clear_inputs(); slot1(1, 1, 5, 1, 2); slot2(1, 1, 6, 3, 4);
    run_cycle(0, 1, 1);
    check_eq("busy_5_6_set", 32'(busy[6:5]), 32'd3);

    clear_inputs(); slot1(1, 0, 0, 5, 0); slot2(1, 0, 0, 0, 0);
    run_cycle(0, 0, 0);
    wb(1, 5, 0, 0);
    run_cycle(0, 1, 1);
    check_eq("busy5_cleared", 32'(busy[5]), 32'd0);
    clear_inputs(); wb(0, 0, 1, 6);
    run_cycle(0, 0, 0);

    clear_inputs(); slot1(1, 1, 7, 0, 0); slot2(1, 0, 0, 7, 0);
    run_cycle(0, 1, 0);
    clear_inputs(); slot1(1, 0, 0, 7, 0);
    run_cycle(0, 0, 0);
    wb(1, 7, 0, 0);
    run_cycle(0, 1, 0);

    clear_inputs(); slot1(1, 1, 8, 0, 0); slot2(1, 1, 8, 0, 0);
    run_cycle(0, 1, 0);
    check_eq("waw_count8_busy", 32'(busy[8]), 32'd1);
    clear_inputs(); wb(1, 8, 0, 0);
    run_cycle(0, 0, 0);

    clear_inputs(); slot1(1, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 0);
    run_cycle(0, 0, 0);
    clear_inputs(); wb(1, 9, 1, 9);
    run_cycle(0, 0, 0);
    check_eq("busy9_after_dual_wb", 32'(busy[9]), 32'd1);
    wb(1, 9, 0, 0);
    run_cycle(0, 0, 0);
    check_eq("err_clear_before_underflow", 32'(err), 32'd0);
    run_cycle(0, 0, 0);
    check_eq("err_after_underflow", 32'(err), 32'd1);

    clear_inputs(); slot1(1, 1, 10, 0, 0);
    run_cycle(0, 1, 0);
    slot1(1, 1, 11, 0, 0); flush = 1'b1;
    run_cycle(0, 1, 0);
    check_eq("flush_busy", busy, 32'd0);
    check_eq("flush_keeps_err", 32'(err), 32'd1);

    clear_inputs(); slot1(1, 1, 12, 0, 0);
    run_cycle(0, 1, 0);
    clear_inputs();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    push_exp("async_rst_busy", 32'd0);
    push_exp("async_rst_err", 32'd0);
    pop_chk(busy);
    pop_chk(32'(err));
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      slot1($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      slot2($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      wb($urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom_range(0, 9) < 4, $urandom_range(0, 7));
      flush = ($urandom_range(0, 39) == 0);
      run_cycle(1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
